// File: rtl/ir_array_decay_timer.sv
// ir_array_decay_timer
//
// Multi-channel RC-discharge IR reflectance front end. Each measurement cycle
// charges every sensor capacitor, then times how long each line takes to decay
// to 0. Per-channel codes are (count >> SHIFT), saturated to the OUT_W all-ones
// value, and published together with per-channel timeout flags and a one-cycle
// valid strobe.
//
// Optional feature (macro IR_THRESHOLD_EN): adds parameter THRESHOLD and output
// isBlack, registered with the codes: isBlack[i] = (code_i >= THRESHOLD) | timeout_i.
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-high reset
//   enable        level; measurement cycles run back-to-back while high
//   inSignal      raw asynchronous sensor lines, channel i is bit i
//   chargeOut     charge drive, all bits equal, high during CHARGE
//   codes         channel i is bits [i*OUT_W +: OUT_W]
//   timeoutFlags  1 = channel did not decay before timeout in the last cycle
//   valid         one-cycle strobe, codes/flags updated this cycle
//   busy          high in CHARGE and MEASURE
//   isBlack       (IR_THRESHOLD_EN only) thresholded line/background decision

module ir_array_decay_timer #(
    parameter int unsigned NCH            = 8,
    parameter int unsigned CHARGE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 67108864,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned SHIFT          = 18,
    parameter int unsigned OUT_W          = 8
`ifdef IR_THRESHOLD_EN
    ,
    parameter int unsigned THRESHOLD      = 100
`endif
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NCH-1:0]         inSignal,
    output logic [NCH-1:0]         chargeOut,
    output logic [NCH*OUT_W-1:0]   codes,
    output logic [NCH-1:0]         timeoutFlags,
    output logic                   valid,
    output logic                   busy
`ifdef IR_THRESHOLD_EN
    ,
    output logic [NCH-1:0]         isBlack
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CHARGE  = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [CNT_W-1:0] CHARGE_LAST  = CNT_W'(CHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CODE_MAX     = CNT_W'((64'd1 << OUT_W) - 64'd1);

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NCH-1:0]       sync1_q, sync_q;
    logic [NCH-1:0]       latched_q, latched_d;
    logic [NCH*OUT_W-1:0] shadow_code_q, shadow_code_d;
    logic [NCH-1:0]       shadow_to_q, shadow_to_d;
    logic [NCH*OUT_W-1:0] codes_q;
    logic [NCH-1:0]       flags_q;
    logic                 valid_q;
    logic                 done_d;

    // One shared saturating code: every channel that latches this cycle sees
    // the same counter value, so a single compare serves all of them.
    logic [CNT_W-1:0] shifted;
    logic [OUT_W-1:0] code_now;

    assign shifted  = cnt_q >> SHIFT;
    assign code_now = (shifted > CODE_MAX) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        latched_d     = latched_q;
        shadow_code_d = shadow_code_q;
        shadow_to_d   = shadow_to_q;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                latched_d = '0;
                if (enable) state_d = S_CHARGE;
            end
            S_CHARGE: begin
                if (cnt_q == CHARGE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_MEASURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MEASURE: begin
                cnt_d = cnt_q + 1'b1;
                for (int i = 0; i < NCH; i++) begin
                    if (!latched_q[i] && !sync_q[i]) begin
                        latched_d[i]                     = 1'b1;
                        shadow_code_d[i*OUT_W +: OUT_W]  = code_now;
                        shadow_to_d[i]                   = 1'b0;
                    end
                end
                if (&latched_d) begin
                    done_d = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Latch check above already ran, so a channel resolving
                    // on the final count keeps its real code and a 0 flag.
                    for (int i = 0; i < NCH; i++) begin
                        if (!latched_d[i]) begin
                            shadow_code_d[i*OUT_W +: OUT_W] = {OUT_W{1'b1}};
                            shadow_to_d[i]                  = 1'b1;
                        end
                    end
                    done_d = 1'b1;
                end
                if (done_d) state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            sync1_q       <= '1;
            sync_q        <= '1;
            latched_q     <= '0;
            shadow_code_q <= '0;
            shadow_to_q   <= '0;
            codes_q       <= '0;
            flags_q       <= '0;
            valid_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; the two sync stages rely on this ordering.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sync1_q       <= inSignal;
            sync_q        <= sync1_q;
            latched_q     <= latched_d;
            shadow_code_q <= shadow_code_d;
            shadow_to_q   <= shadow_to_d;
            valid_q       <= done_d;
            // Outputs load on the edge into DONE so they are already stable
            // while valid is high during DONE.
            if (done_d) begin
                codes_q <= shadow_code_d;
                flags_q <= shadow_to_d;
            end
        end
    end

`ifdef IR_THRESHOLD_EN
    logic [NCH-1:0] black_q, black_d;

    always_comb begin
        black_d = '0;
        for (int i = 0; i < NCH; i++) begin
            black_d[i] = (32'(shadow_code_d[i*OUT_W +: OUT_W]) >= THRESHOLD) | shadow_to_d[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            black_q <= '0;
        end else if (done_d) begin
            black_q <= black_d;
        end
    end

    assign isBlack = black_q;
`endif

    assign chargeOut    = {NCH{state_q == S_CHARGE}};
    assign busy         = (state_q == S_CHARGE) || (state_q == S_MEASURE);
    assign codes        = codes_q;
    assign timeoutFlags = flags_q;
    assign valid        = valid_q;

endmodule

// File: doc/ir_array_decay_timer.md
# ir_array_decay_timer

Multi-channel reflectance-sensor front end for RC-discharge infrared sensors. Each cycle charges all sensor capacitors and measures, per channel, how long the line takes to decay to logic 0. It publishes scaled, saturated decay codes with a valid strobe and per-channel timeout flags. It replaces the single-channel counter in the line-follower datapath and feeds the NIOS II register bank directly.

## Interface
Parameters:
- NCH, 8, number of sensor channels
- CHARGE_CYCLES, 1024, clock cycles the charge drive is held high (≥1)
- TIMEOUT_CYCLES, 67108864, maximum measure cycles before unresolved channels time out (≥2)
- CNT_W, 32, measure counter width; must hold TIMEOUT_CYCLES-1
- SHIFT, 18, right shift applied to the raw count to form a code
- OUT_W, 8, code width per channel

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  level; while high, measurement cycles run back-to-back
- inSignal  in  NCH  raw, asynchronous sensor lines; channel i is bit i
- chargeOut  out  NCH  charge drive, all bits equal
- codes  out  NCH*OUT_W  channel i is bits [i*OUT_W +: OUT_W]
- timeoutFlags  out  NCH  1 = channel did not decay before timeout in the last cycle
- valid  out  1  one-cycle strobe; codes and flags were updated this cycle
- busy  out  1  high in CHARGE and MEASURE

## Operation
- Each inSignal bit passes through a 2-flop synchronizer; all decisions use the synchronized value (sync).
- FSM states:
  - IDLE: counter cleared, all latch bits cleared. If enable=1, go to CHARGE.
  - CHARGE: chargeOut is all ones. Counter runs 0..CHARGE_CYCLES-1. At the last count, clear the counter and go to MEASURE.
  - MEASURE: chargeOut is 0 and the counter increments every cycle.
    - For each unlatched channel with sync=0, latch code = min(counter>>SHIFT, 2^OUT_W-1) into the shadow register and clear its shadow timeout bit.
    - Leave MEASURE for DONE when every channel is latched, including channels latched this cycle.
    - Also leave for DONE when counter == TIMEOUT_CYCLES-1. Every channel still unlatched after this cycle's latch check gets shadow code 2^OUT_W-1 and shadow timeout bit 1.
  - DONE: copy shadow codes and flags to codes/timeoutFlags atomically, assert valid, go to IDLE.
- A channel latches at most once per cycle. Later glitches are ignored.
- Latch and timeout in the same cycle: the latch wins (timeout bit 0). Its code is the saturated value computed from TIMEOUT_CYCLES-1.
- Dropping enable mid-cycle does not abort; the current cycle completes through DONE.
- codes and timeoutFlags hold between valid strobes.
- Arithmetic is unsigned. Saturation is a compare of the shifted value against the OUT_W all-ones value, never truncation.

## Timing
- Reset (any state, including mid-MEASURE):
  - Next edge: state IDLE, chargeOut=0, codes=0, timeoutFlags=0, valid=0, busy=0.
  - Synchronizers cleared to 1. Shadow registers cleared.
- IDLE with enable=1 enters CHARGE on the next edge.
- chargeOut is high for exactly CHARGE_CYCLES consecutive cycles.
- The first MEASURE cycle has counter=0. A channel whose sync is already 0 there gets code 0.
- A raw falling edge appears at sync 2 cycles later. Codes reflect the counter at sync detection.
- valid rises the cycle after the final MEASURE cycle and is high for exactly 1 cycle.
- Back-to-back cycles with enable held high: cycle period = 1 (IDLE) + CHARGE_CYCLES + measure cycles + 1 (DONE).

## Configuration
- IR_THRESHOLD_EN defined:
  - Adds parameter THRESHOLD (default 100) and output port isBlack [NCH-1:0].
  - isBlack[i] = (code_i ≥ THRESHOLD) | timeout_i.
  - isBlack is registered in DONE together with codes. Reset value 0.
- IR_THRESHOLD_EN undefined: no THRESHOLD parameter, no isBlack port, no comparator logic.

## Test plan
Bench parameters: NCH=4, CHARGE_CYCLES=16, TIMEOUT_CYCLES=4096, SHIFT=4, OUT_W=8.
- Reset with enable=0 -> all outputs 0. Assert enable -> chargeOut=4'hF for exactly 16 cycles, busy=1.
- sync lines first low at counters 100/200/300/400 on ch0..3 -> codes 6/12/18/25, flags 0. valid one cycle, the cycle after counter 400.
- ch2 held high -> ch2 code 255, timeoutFlags=4'b0100. MEASURE ends at counter 4095.
- SHIFT=2, ch0 low at counter 2000 -> code saturates to 255 (not 244), flag 0.
- All lines low at MEASURE start -> all codes 0. valid in the 2nd cycle after CHARGE ends.
- Reset asserted at counter 50 of MEASURE -> next cycle all outputs 0, state IDLE. No valid pulse follows.
